// File: rtl/regdecode_pkg.sv
// ============================================================================
// Module   : regdecode_pkg
// Brief    : Shared defaults and types for the banked register decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regdecode_pkg;

    localparam int BANK_W_DFLT      = 2;
    localparam int LO_W_DFLT        = 2;
    localparam int STACK_DEPTH_DFLT = 4;
    localparam int ADDR_W           = BANK_W_DFLT + LO_W_DFLT;

    typedef logic [BANK_W_DFLT-1:0] bank_t;

endpackage

`default_nettype wire

// File: rtl/bank_stack.sv
// ============================================================================
// Module   : bank_stack
// Brief    : Saturating LIFO of bank values; simultaneous push+pop is a no-op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bank_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             pop_ok,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_single_push;
    logic             w_single_pop;
    logic [PTR_W-1:0] w_top_idx;

    // Push and pop together cancel out: nothing moves and nothing is flagged.
    assign w_single_push = push & ~pop;
    assign w_single_pop  = pop & ~push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = w_single_push & ~full;
    assign pop_ok    = w_single_pop & ~empty;
    assign overflow  = w_single_push & full;
    assign underflow = w_single_pop & empty;

    assign w_top_idx = PTR_W'(r_count - CNT_W'(1));
    assign dout      = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_push_ok) begin
            r_count <= r_count + CNT_W'(1);
        end else if (pop_ok) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_count[PTR_W-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/banked_reg_decode.sv
// ============================================================================
// Module   : banked_reg_decode
// Brief    : Widens instruction register fields with the active bank; the
//            optional bank stack is enabled by defining BANK_STACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module banked_reg_decode
    import regdecode_pkg::*;
#(
    parameter int BANK_W      = BANK_W_DFLT,
    parameter int LO_W        = LO_W_DFLT,
    parameter int STACK_DEPTH = STACK_DEPTH_DFLT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_bank_valid,
    input  logic [BANK_W-1:0]      set_bank,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   err_clr,
    input  logic [LO_W-1:0]        src_a_lo,
    input  logic [LO_W-1:0]        src_b_lo,
    input  logic [LO_W-1:0]        dst_lo,
    output logic [BANK_W+LO_W-1:0] src_a_addr,
    output logic [BANK_W+LO_W-1:0] src_b_addr,
    output logic [BANK_W+LO_W-1:0] dst_addr,
    output logic [BANK_W-1:0]      bank,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   stack_err
);

    localparam int FULL_W = BANK_W + LO_W;

    logic [BANK_W-1:0] r_bank;
    logic [FULL_W-1:0] r_src_a_addr;
    logic [FULL_W-1:0] r_src_b_addr;
    logic [FULL_W-1:0] r_dst_addr;
    logic [BANK_W-1:0] w_eff_bank;
    logic [BANK_W-1:0] w_top;
    logic              w_pop_ok;

`ifdef BANK_STACK_EN
    logic w_overflow;
    logic w_underflow;
    logic r_err;

    bank_stack #(
        .WIDTH (BANK_W),
        .DEPTH (STACK_DEPTH)
    ) u_bank_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (r_bank),
        .dout      (w_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .pop_ok    (w_pop_ok),
        .overflow  (w_overflow),
        .underflow (w_underflow)
    );

    // A fresh error outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_overflow | w_underflow) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign stack_err = r_err;
`else
    logic w_unused_stack_ctrl;

    assign w_unused_stack_ctrl = &{1'b0, push, pop, err_clr, (STACK_DEPTH > 1)};
    assign w_pop_ok            = 1'b0;
    assign w_top               = '0;
    assign stack_full          = 1'b0;
    assign stack_empty         = 1'b1;
    assign stack_err           = 1'b0;
`endif

    always_comb begin
        w_eff_bank = r_bank;
        if (set_bank_valid) begin
            w_eff_bank = set_bank;
        end else if (w_pop_ok) begin
            w_eff_bank = w_top;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank       <= '0;
            r_src_a_addr <= '0;
            r_src_b_addr <= '0;
            r_dst_addr   <= '0;
        end else begin
            r_bank       <= w_eff_bank;
            r_src_a_addr <= {w_eff_bank, src_a_lo};
            r_src_b_addr <= {w_eff_bank, src_b_lo};
            r_dst_addr   <= {w_eff_bank, dst_lo};
        end
    end

    assign bank       = r_bank;
    assign src_a_addr = r_src_a_addr;
    assign src_b_addr = r_src_b_addr;
    assign dst_addr   = r_dst_addr;

endmodule

`default_nettype wire
